// File: rtl/multirate_pkg.sv
// Shared constants, types and the round/saturate helper for the decimating
// FIR accumulator.
package multirate_pkg;

  localparam int unsigned PROD_W     = 27;
  localparam int unsigned GUARD_W    = 6;
  localparam int unsigned ACC_W      = PROD_W + GUARD_W;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned FRAC_SHIFT = 10;
  localparam int unsigned MAX_TAPS   = 64;
  localparam int unsigned TAP_W      = $clog2(MAX_TAPS + 1);
  localparam int unsigned RND_W      = ACC_W + 1 - FRAC_SHIFT;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  sample_t;

  typedef struct packed {
    sample_t data;
    logic    sat;
  } rs_t;

  localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W + 1)'(1) << (FRAC_SHIFT - 1);

  // Round half-up then clamp; one extra bit keeps the bias add from wrapping.
  function automatic rs_t round_sat(input acc_t a);
    logic signed [ACC_W:0] biased;
    logic [RND_W-1:0]      r;
    logic [RND_W-OUT_W:0]  hi;
    rs_t                   res;
    biased = $signed({a[ACC_W-1], a}) + RND_BIAS;
    r      = biased[ACC_W:FRAC_SHIFT];
    // In range only when every bit from the output sign bit upward agrees.
    hi       = r[RND_W-1:OUT_W-1];
    res.sat  = !((&hi) || !(|hi));
    res.data = r[OUT_W-1:0];
    if (res.sat) begin
      res.data = r[RND_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/multirate_fifo2.sv
// Two-entry synchronous FIFO with valid/ready on both sides and an occupancy
// count.
module multirate_fifo2
  import multirate_pkg::*;
(
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic signed [OUT_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              count
);

  logic [OUT_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multirate_fir_accum.sv
// Frame accumulator for polyphase FIR products: sums a frame, rounds and
// saturates to a 16-bit sample, and queues results in a 2-entry FIFO.
module multirate_fir_accum
  import multirate_pkg::*;
(
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] prod_data,
  input  logic                     prod_valid,
  input  logic                     prod_last,
  output logic                     prod_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     err_clr,
  output logic                     sat_err,
  output logic                     ovf_err
);

  logic [TAP_W-1:0] tap_cnt;
  acc_t             acc;
  acc_t             acc_next;
  acc_t             stage_reg;
  logic             stage_valid;
  logic [1:0]       fifo_count;
  logic             fifo_in_ready;
  logic             accept;
  logic             hit_max;
  logic             close;
  logic             push;
  rs_t              rs;

  // Ready depends only on registered occupancy so out_ready never reaches it.
  assign prod_ready = ({1'b0, fifo_count} + {2'b00, stage_valid}) < 3'd2;
  assign accept     = prod_valid && prod_ready;
  assign hit_max    = (tap_cnt == TAP_W'(MAX_TAPS - 1));
  assign close      = accept && (prod_last || hit_max);
  assign push       = stage_valid && fifo_in_ready;
  assign rs         = round_sat(stage_reg);

  always_comb begin
    acc_next = (tap_cnt == '0) ? '0 : acc;
    acc_next = acc_next + acc_t'(prod_data);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tap_cnt     <= '0;
      acc         <= '0;
      stage_reg   <= '0;
      stage_valid <= 1'b0;
      sat_err     <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      if (accept) begin
        acc     <= acc_next;
        tap_cnt <= close ? '0 : tap_cnt + TAP_W'(1);
      end
      // A new close may overwrite the stage in the same edge it drains.
      if (close) begin
        stage_reg   <= acc_next;
        stage_valid <= 1'b1;
      end else if (push) begin
        stage_valid <= 1'b0;
      end
      if (push && rs.sat)                     sat_err <= 1'b1;
      else if (err_clr)                       sat_err <= 1'b0;
      if (accept && hit_max && !prod_last)    ovf_err <= 1'b1;
      else if (err_clr)                       ovf_err <= 1'b0;
    end
  end

  multirate_fifo2 u_fifo (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_data   (rs.data),
    .in_valid  (stage_valid),
    .in_ready  (fifo_in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (fifo_count)
  );

endmodule
